mux_scan_nch: RTL and testbench
===============================

// Module: mux_scan_nch
// PURPOSE
//   Parametrised, registered N-channel, W-bit selector. Next generation of the 4-input 1-bit mux.
//   Manual mode: the output follows an external select.
//   Scan mode: an internal sequencer steps through all channels with a programmable dwell time.
//   Sits between the input channel bank and downstream logic that needs either a fixed channel or a time-multiplexed stream.
// PARAMETERS
//   WIDTH      8   bits per channel
//   NCH        4   number of channels (2..16; need not be a power of 2)
//   DWELL      4   clock cycles each channel is held in scan mode (>=1)
//   REV_ORDER  1   1: select value k picks channel NCH-1-k (legacy mapping, 0 -> highest channel); 0: k picks channel k
//   SEL_W      $clog2(NCH)   derived; do not override
// PORTS
//   clk         in   1             rising-edge clock
//   rst_n       in   1             synchronous active-low reset
//   din         in   NCH*WIDTH     flat channel bus; channel i = din[i*WIDTH +: WIDTH]
//   sel         in   SEL_W         manual channel select (mapped per REV_ORDER)
//   mode        in   1             0 = MANUAL, 1 = SCAN
//   en          in   1             global enable; 0 freezes all state and outputs
//   dout        out  WIDTH         registered selected channel data
//   dout_valid  out  1             dout holds a legal, selected sample
//   cur_ch      out  SEL_W         physical channel index currently driving dout
//   scan_wrap   out  1             1-cycle pulse when the scan returns from the last channel to the first
//   sel_err     out  1             registered; manual sel maps outside 0..NCH-1
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): dout=0, dout_valid=0, cur_ch=0, scan_wrap=0, sel_err=0, dwell_cnt=0, state=IDLE.
//     - Reset overrides en and mode and takes effect mid-scan.
//   States: IDLE, MANUAL, SCAN. Transitions are evaluated only when en=1.
//     - IDLE -> MANUAL if mode=0; IDLE -> SCAN if mode=1.
//     - MANUAL -> SCAN when mode=1: scan starts at physical channel 0 and dwell_cnt is cleared.
//     - SCAN -> MANUAL when mode=0: takes effect the same edge; the scan position is discarded.
//   MANUAL: every enabled edge, ch = REV_ORDER ? NCH-1-sel : sel.
//     - If ch is in range: dout <= din[ch], cur_ch <= ch, dout_valid <= 1, sel_err <= 0.
//     - If ch is out of range (sel >= NCH): dout and cur_ch hold, dout_valid <= 0, sel_err <= 1.
//     - Latency: 1 cycle from sel/din change to dout.
//   SCAN: dout <= din[cur_ch] on every enabled edge, so live data is tracked during the dwell.
//     - dout_valid <= 1. sel is ignored and sel_err <= 0.
//     - dwell_cnt counts 0..DWELL-1. When dwell_cnt=DWELL-1, cur_ch advances to the next channel in the order set by REV_ORDER, and dwell_cnt returns to 0.
//     - REV_ORDER=1 steps NCH-1 down to 0; REV_ORDER=0 steps 0 up to NCH-1.
//     - Exception: entry into SCAN always starts at physical channel 0.
//     - Wrap-around: when advancing from the last channel in the order to the first, scan_wrap=1 for exactly one cycle, registered with the cur_ch update.
//     - With DWELL=1, cur_ch changes every enabled cycle.
//   en=0: all registers hold, including dwell_cnt and the state; scan_wrap is forced to 0.
//     - Resuming with en=1 continues exactly where the block stopped.
//   Simultaneous events:
//     - Mode change on the same edge as a dwell expiry: the mode change wins and no scan_wrap is issued.
//     - Reset wins over everything.
//   All outputs are registered; there is no combinational path from inputs to outputs.
// TESTING
//   1. WIDTH=8, NCH=4, REV_ORDER=1; reset; mode=0, sel=0, din ch3=0xA5 ->
//        next edge: dout=0xA5, cur_ch=3, dout_valid=1.
//   2. NCH=5, REV_ORDER=0, mode=0, sel=6 ->
//        sel_err=1, dout_valid=0, dout holds previous value.
//      Then sel=2 -> sel_err=0, dout=din ch2.
//   3. NCH=4, DWELL=3, REV_ORDER=0, mode=1, din ch k = 0x10+k ->
//        dout sequence 0x10 x3, 0x11 x3, 0x12 x3, 0x13 x3, 0x10.
//      scan_wrap pulses once, on the edge where cur_ch goes 3->0.
//   4. SCAN with DWELL=4; drop en for 5 cycles mid-dwell ->
//        dout, cur_ch and dwell_cnt are frozen and scan_wrap=0.
//      After en=1, the remaining dwell cycles complete unchanged.
//   5. SCAN on cur_ch=2; assert rst_n=0 for one edge ->
//        all outputs are 0 next cycle.
//      Release with mode=1 -> IDLE, then scan from channel 0.
//   6. mode toggles 1->0 on the same edge as a dwell expiry on the last channel ->
//        no scan_wrap; dout follows sel on the next edge.

Source files
------------

// File: rtl/mux_scan_nch_if.sv
// Channel-bank / selector bus for mux_scan_nch: flat channel data and controls in,
// selected sample and status out.
interface mux_scan_nch_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   localparam int SEL_W = $clog2(NCH);

   logic [NCH*WIDTH-1:0] din;
   logic [SEL_W-1:0]     sel;
   logic                 mode;
   logic                 en;
   logic [WIDTH-1:0]     dout;
   logic                 dout_valid;
   logic [SEL_W-1:0]     cur_ch;
   logic                 scan_wrap;
   logic                 sel_err;

   modport master (
      output din, sel, mode, en,
      input  dout, dout_valid, cur_ch, scan_wrap, sel_err
   );

   modport slave (
      input  din, sel, mode, en,
      output dout, dout_valid, cur_ch, scan_wrap, sel_err
   );
endinterface

// File: rtl/mux_scan_nch.sv
// Registered N-channel selector: manual channel select or timed scan across all channels.
//   state    | meaning
//   S_IDLE   | out of reset, nothing selected yet
//   S_MANUAL | dout follows the external select
//   S_SCAN   | sequencer steps through channels, DWELL cycles each
module mux_scan_nch #(
   parameter int WIDTH     = 8,
   parameter int NCH       = 4,
   parameter int DWELL     = 4,
   parameter int REV_ORDER = 1,
   localparam int SEL_W    = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   mux_scan_nch_if.slave  bus
);

   localparam int                DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NCH - 1);
   localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL - 1);
   // Physical channel that ends one pass of the scan order
   localparam logic [SEL_W-1:0]  SCAN_END = (REV_ORDER != 0) ? '0 : LAST_CH;

   typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              valid_q, valid_d;
   logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;

   logic [SEL_W-1:0]  man_ch;
   logic              sel_oob;
   logic [SEL_W-1:0]  scan_nxt;

   function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] v,
                                             input logic [SEL_W-1:0]     ch);
      return v[int'(ch)*WIDTH +: WIDTH];
   endfunction

   always_comb begin
      man_ch  = (REV_ORDER != 0) ? (LAST_CH - bus.sel) : bus.sel;
      sel_oob = (int'(bus.sel) >= NCH);
      if (REV_ORDER != 0)
         scan_nxt = (cur_ch_q == '0) ? LAST_CH : (cur_ch_q - SEL_W'(1));
      else
         scan_nxt = (cur_ch_q == LAST_CH) ? '0 : (cur_ch_q + SEL_W'(1));
   end

   always_comb begin
      state_d  = state_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      cur_ch_d = cur_ch_q;
      dwell_d  = dwell_q;
      err_d    = err_q;
      wrap_d   = 1'b0;
      if (bus.en) begin
         if (!bus.mode) begin
            // Leaving scan discards the scan position; an expiring dwell is ignored
            state_d = S_MANUAL;
            if (sel_oob) begin
               valid_d = 1'b0;
               err_d   = 1'b1;
            end else begin
               cur_ch_d = man_ch;
               dout_d   = pick(bus.din, man_ch);
               valid_d  = 1'b1;
               err_d    = 1'b0;
            end
         end else if (state_q != S_SCAN) begin
            state_d  = S_SCAN;
            cur_ch_d = '0;
            dwell_d  = '0;
            dout_d   = pick(bus.din, '0);
            valid_d  = 1'b1;
            err_d    = 1'b0;
         end else begin
            valid_d = 1'b1;
            err_d   = 1'b0;
            if (dwell_q == DW_LAST) begin
               dwell_d  = '0;
               cur_ch_d = scan_nxt;
               wrap_d   = (cur_ch_q == SCAN_END);
            end else begin
               dwell_d = dwell_q + DW_W'(1);
            end
            dout_d = pick(bus.din, cur_ch_d);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         cur_ch_q <= '0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         cur_ch_q <= cur_ch_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
         dwell_q  <= dwell_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
   assign bus.cur_ch     = cur_ch_q;
   assign bus.scan_wrap  = wrap_q;
   assign bus.sel_err    = err_q;

endmodule

// File: tb/tb_mux_scan_nch.sv
// Scoreboard bench for mux_scan_nch: two configurations driven side by side and
// checked every cycle against a channel-order reference model.
module tb_mux_scan_nch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic mode = 1'b0;
   int   sel_a = 0;
   int   sel_b = 0;
   logic [7:0] ch_a [4];
   logic [7:0] ch_b [5];

   always #5 clk = ~clk;

   mux_scan_nch_if #(.WIDTH(8), .NCH(4)) bus_a ();
   mux_scan_nch_if #(.WIDTH(8), .NCH(5)) bus_b ();

   // A: legacy reverse mapping, 4 channels, dwell 4
   mux_scan_nch #(.WIDTH(8), .NCH(4), .DWELL(4), .REV_ORDER(1)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   // B: natural mapping, 5 channels (non power of two), dwell 3
   mux_scan_nch #(.WIDTH(8), .NCH(5), .DWELL(3), .REV_ORDER(0)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct {
      int         dut;
      string      tag;
      logic [7:0] dout;
      bit         valid;
      int         cur;
      bit         wrap;
      bit         err;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

   // reference model: scan position is an index into the channel visiting order
   int         m_st [2];   // 0 idle, 1 manual, 2 scan
   int         m_pos[2];
   int         m_dw [2];
   int         m_cur[2];
   logic [7:0] m_dout[2];
   bit         m_valid[2];
   bit         m_wrap[2];
   bit         m_err[2];

   function automatic int nch_of(int d);   return (d == 0) ? 4 : 5; endfunction
   function automatic int dwell_of(int d); return (d == 0) ? 4 : 3; endfunction
   function automatic bit rev_of(int d);   return (d == 0);         endfunction

   function automatic int order(int d, int p);
      return rev_of(d) ? (nch_of(d) - 1 - p) : p;
   endfunction

   function automatic logic [7:0] chv(int d, int ch);
      if (d == 0) return ch_a[ch];
      return ch_b[ch];
   endfunction

   function automatic void model_step(int d, int sel);
      int n;
      n = nch_of(d);
      if (!rst_n) begin
         m_st[d] = 0; m_pos[d] = 0; m_dw[d] = 0; m_cur[d] = 0;
         m_dout[d] = 8'h00; m_valid[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
         return;
      end
      m_wrap[d] = 0;
      if (!en) return;
      if (!mode) begin
         m_st[d] = 1;
         if (sel >= n) begin
            m_valid[d] = 0;
            m_err[d]   = 1;
         end else begin
            m_cur[d]   = rev_of(d) ? (n - 1 - sel) : sel;
            m_dout[d]  = chv(d, m_cur[d]);
            m_valid[d] = 1;
            m_err[d]   = 0;
         end
      end else if (m_st[d] != 2) begin
         m_st[d]  = 2;
         m_pos[d] = rev_of(d) ? (n - 1) : 0;   // always lands on physical channel 0
         m_dw[d]  = 0;
         m_cur[d] = order(d, m_pos[d]);
         m_dout[d] = chv(d, m_cur[d]);
         m_valid[d] = 1;
         m_err[d] = 0;
      end else begin
         if (m_dw[d] == dwell_of(d) - 1) begin
            m_dw[d] = 0;
            if (m_pos[d] == n - 1) m_wrap[d] = 1;
            m_pos[d] = (m_pos[d] + 1) % n;
         end else begin
            m_dw[d]++;
         end
         m_cur[d]   = order(d, m_pos[d]);
         m_dout[d]  = chv(d, m_cur[d]);
         m_valid[d] = 1;
         m_err[d]   = 0;
      end
   endfunction

   task automatic pack();
      bus_a.en   = en;
      bus_b.en   = en;
      bus_a.mode = mode;
      bus_b.mode = mode;
      bus_a.sel  = 2'(sel_a);
      bus_b.sel  = 3'(sel_b);
      for (int i = 0; i < 4; i++) bus_a.din[i*8 +: 8] = ch_a[i];
      for (int i = 0; i < 5; i++) bus_b.din[i*8 +: 8] = ch_b[i];
   endtask

   task automatic rand_din();
      for (int i = 0; i < 4; i++) ch_a[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) ch_b[i] = 8'($urandom);
   endtask

   task automatic tick(input string tag);
      exp_t e;
      pack();
      model_step(0, sel_a);
      model_step(1, sel_b);
      for (int d = 0; d < 2; d++) begin
         e.dut = d; e.tag = tag; e.dout = m_dout[d]; e.valid = m_valid[d];
         e.cur = m_cur[d]; e.wrap = m_wrap[d]; e.err = m_err[d];
         sbq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // monitor: outputs are registered, so every cycle presents a sample to check
   always @(posedge clk) begin
      exp_t       e;
      logic [7:0] a_dout;
      bit         a_v, a_w, a_e;
      int         a_cur;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.dut == 0) begin
            a_dout = bus_a.dout; a_v = bus_a.dout_valid; a_cur = int'(bus_a.cur_ch);
            a_w = bus_a.scan_wrap; a_e = bus_a.sel_err;
         end else begin
            a_dout = bus_b.dout; a_v = bus_b.dout_valid; a_cur = int'(bus_b.cur_ch);
            a_w = bus_b.scan_wrap; a_e = bus_b.sel_err;
         end
         n_vec++;
         if (a_dout !== e.dout || a_v !== e.valid || a_cur != e.cur ||
             a_w !== e.wrap || a_e !== e.err) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got dout=%02h valid=%0d cur=%0d wrap=%0d err=%0d, expected dout=%02h valid=%0d cur=%0d wrap=%0d err=%0d",
                     e.tag, e.dut, $time, a_dout, a_v, a_cur, a_w, a_e,
                     e.dout, e.valid, e.cur, e.wrap, e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rand_din();
      rst_n = 1'b0; en = 1'b1; mode = 1'b1;
      tick("reset");
      en = 1'b0; mode = 1'b0;
      tick("reset");

      // manual select: A legacy mapping sel 0 -> ch3; B out-of-range then valid
      rst_n = 1'b1; en = 1'b1; mode = 1'b0;
      rand_din(); ch_a[3] = 8'hA5; sel_a = 0; sel_b = 6;
      tick("manual_first");
      rand_din(); sel_a = 2; sel_b = 2;
      tick("manual_sel2");
      rand_din(); sel_a = 1; sel_b = 7;
      tick("manual_oob");
      rand_din(); sel_b = 4;
      tick("manual_last");

      // scan with live data, long enough to wrap both configurations
      mode = 1'b1;
      for (int i = 0; i < 36; i++) begin rand_din(); tick("scan_run"); end

      // freeze mid-dwell, then resume
      rand_din(); tick("scan_pre_hold");
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin rand_din(); tick("en_hold"); end
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin rand_din(); tick("resume"); end

      // reset mid-scan, release straight back into scan
      rst_n = 1'b0;
      rand_din(); tick("mid_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin rand_din(); tick("rescan"); end

      // leave scan on the very edge A would wrap
      guard = 0;
      while (!(m_st[0] == 2 && m_pos[0] == 3 && m_dw[0] == 3) && guard < 40) begin
         rand_din(); tick("seek_wrap"); guard++;
      end
      if (guard >= 40) begin
         n_err++;
         $display("FAIL seek_wrap: scan never reached last channel expiry within %0d cycles", guard);
      end
      mode = 1'b0; sel_a = 1; sel_b = 3;
      rand_din(); tick("mode_vs_wrap");
      rand_din(); sel_a = 3; tick("after_mode_change");

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         en    = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel_a = $urandom_range(0, 3);
         sel_b = $urandom_range(0, 7);
         rand_din();
         tick("random");
      end

      @(posedge clk);
      #3;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected samples never checked, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
